// File: rtl/dac_slew_driver.sv
// ---------------------------------------------------------------------------
// dac_slew_driver
//
// Takes the signed DAC code from the voltage-to-code converter and moves a
// registered output code toward it at a bounded rate. This keeps the SPGD
// actuator from seeing large single-step jumps. The code is clamped to
// [CODE_MIN, CODE_MAX] on capture. It is then converted to the DAC pin format
// and registered once more before it drives the DAC bus.
//
// Parameters
//   DAC_WIDTH     width of code_in, the internal codes and dac_dat
//   STEP          largest code change per update tick; 0 jumps straight to target
//   UPDATE_DIV    clocks per update tick (>= 1)
//   CODE_MAX/MIN  signed clamp limits, CODE_MIN <= CODE_MAX
//   OFFSET_BINARY 1: MSB inverted on the pins, 0: two's complement on the pins
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   code_in       signed target code, sampled when code_valid is high
//   code_valid    capture strobe (no backpressure)
//   hold          freezes stepping; targets are still captured
//   dac_dat       registered DAC pin data, one clock behind cur_code
//   cur_code      current signed output code
//   busy          high while ramping toward the target
//   settled       one-cycle pulse when the output lands on the target
//   clamped       set when the last captured code was out of range
// ---------------------------------------------------------------------------
module dac_slew_driver #(
    parameter int DAC_WIDTH     = 14,
    parameter int STEP          = 64,
    parameter int UPDATE_DIV    = 8,
    parameter int CODE_MAX      = 8191,
    parameter int CODE_MIN      = -8192,
    parameter bit OFFSET_BINARY = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DAC_WIDTH-1:0] code_in,
    input  logic                        code_valid,
    input  logic                        hold,
    output logic        [DAC_WIDTH-1:0] dac_dat,
    output logic signed [DAC_WIDTH-1:0] cur_code,
    output logic                        busy,
    output logic                        settled,
    output logic                        clamped
);

    localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(UPDATE_DIV - 1);
    localparam logic signed [DAC_WIDTH-1:0] MAX_C    = DAC_WIDTH'(CODE_MAX);
    localparam logic signed [DAC_WIDTH-1:0] MIN_C    = DAC_WIDTH'(CODE_MIN);
    localparam logic signed [DAC_WIDTH-1:0] STEP_N   = DAC_WIDTH'(STEP);
    localparam logic signed [DAC_WIDTH:0]   STEP_W   = (DAC_WIDTH + 1)'(STEP);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t                        state;
    logic signed [DAC_WIDTH-1:0]   cur;
    logic signed [DAC_WIDTH-1:0]   target;
    logic        [CNT_W-1:0]       tick_cnt;

    logic                          tick;
    logic                          over_hi;
    logic                          under_lo;
    logic signed [DAC_WIDTH-1:0]   clamp_val;
    logic signed [DAC_WIDTH-1:0]   next_tgt;
    logic signed [DAC_WIDTH:0]     diff;
    logic signed [DAC_WIDTH:0]     abs_diff;
    logic                          near;
    logic signed [DAC_WIDTH-1:0]   step_val;

    // Pin format. With offset binary the most negative code maps to 0 and
    // zero maps to midscale.
    function automatic logic [DAC_WIDTH-1:0] format_code(input logic signed [DAC_WIDTH-1:0] c);
        if (OFFSET_BINARY)
            return {~c[DAC_WIDTH-1], c[DAC_WIDTH-2:0]};
        else
            return c;
    endfunction

    assign cur_code = cur;
    assign tick     = (tick_cnt == CNT_LAST);

    // NOTE: every signal here is assigned on every path through the block, so
    // no latch can be inferred.
    always_comb begin
        over_hi   = (code_in > MAX_C);
        under_lo  = (code_in < MIN_C);
        clamp_val = over_hi ? MAX_C : (under_lo ? MIN_C : code_in);
        next_tgt  = code_valid ? clamp_val : target;

        // One extra bit keeps target - cur exact across the full code range.
        diff      = {target[DAC_WIDTH-1], target} - {cur[DAC_WIDTH-1], cur};
        abs_diff  = diff[DAC_WIDTH] ? -diff : diff;
        near      = (abs_diff <= STEP_W);

        // When not near, a full STEP stays strictly between cur and target,
        // so the add/subtract cannot wrap.
        if (near)
            step_val = target;
        else if (diff[DAC_WIDTH])
            step_val = cur - STEP_N;
        else
            step_val = cur + STEP_N;
    end

    // NOTE: state registers use non-blocking assignments so every branch reads
    // the values from before this edge. This matters because the step has to
    // use the old target when a capture lands on a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            target   <= '0;
            tick_cnt <= '0;
            dac_dat  <= format_code('0);
            busy     <= 1'b0;
            settled  <= 1'b0;
            clamped  <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            settled  <= 1'b0;
            dac_dat  <= format_code(cur);

            if (code_valid) begin
                target  <= clamp_val;
                clamped <= over_hi | under_lo;
            end

            if (STEP == 0) begin
                // No slew limit: follow the target on the capture edge. If a
                // capture arrives during hold, the jump happens on the first
                // cycle after hold releases.
                if (!hold && (next_tgt != cur)) begin
                    cur     <= next_tgt;
                    settled <= 1'b1;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (code_valid && (clamp_val != cur)) begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end
                    RAMP: begin
                        if (tick && !hold) begin
                            cur <= step_val;
                            // Leave only if the landing point matches the
                            // target in force after this edge. A retarget on
                            // the landing tick keeps ramping.
                            if (step_val == next_tgt) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                settled <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_slew_driver.sv
// ---------------------------------------------------------------------------
// Testbench for dac_slew_driver.
// Instance "a" is slew limited: STEP=64, UPDATE_DIV=8, CODE_MAX=4000.
// Instance "b" has no slew limit: STEP=0, UPDATE_DIV=1.
// A reference model advances once per clock edge from the behavioural rules.
// It pushes the expected outputs into a queue. A monitor on the falling edge
// pops that queue and compares. Landing codes go to a second queue that is
// consumed whenever instance "a" pulses settled.
// ---------------------------------------------------------------------------
module tb_dac_slew_driver;

    localparam int W      = 14;
    localparam int A_STEP = 64;
    localparam int A_DIV  = 8;
    localparam int A_MAX  = 4000;
    localparam int A_MIN  = -8192;
    localparam int B_STEP = 0;
    localparam int B_DIV  = 1;
    localparam int B_MAX  = 8191;
    localparam int B_MIN  = -8192;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic signed [W-1:0] code_in = '0;
    logic code_valid = 1'b0;
    logic hold       = 1'b0;

    logic        [W-1:0] a_dac,  b_dac;
    logic signed [W-1:0] a_cur,  b_cur;
    logic a_busy, a_settled, a_clamped;
    logic b_busy, b_settled, b_clamped;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dac_slew_driver #(
        .DAC_WIDTH(W), .STEP(A_STEP), .UPDATE_DIV(A_DIV),
        .CODE_MAX(A_MAX), .CODE_MIN(A_MIN), .OFFSET_BINARY(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
        .hold(hold), .dac_dat(a_dac), .cur_code(a_cur), .busy(a_busy),
        .settled(a_settled), .clamped(a_clamped)
    );

    dac_slew_driver #(
        .DAC_WIDTH(W), .STEP(B_STEP), .UPDATE_DIV(B_DIV),
        .CODE_MAX(B_MAX), .CODE_MIN(B_MIN), .OFFSET_BINARY(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
        .hold(1'b0), .dac_dat(b_dac), .cur_code(b_cur), .busy(b_busy),
        .settled(b_settled), .clamped(b_clamped)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        int cur;
        int tgt;
        bit ramp;
        bit settled;
        bit clamped;
        int dac;
    } mstate_t;

    typedef struct packed {
        mstate_t a;
        mstate_t b;
    } exp_t;

    exp_t exp_q[$];
    int   settle_q[$];

    // Offset-binary pin value of a 14-bit signed code.
    function automatic int fmt_ob(input int c);
        return (c + 8192) % 16384;
    endfunction

    function automatic mstate_t model_edge(input mstate_t m, input int code, input bit valid,
                                           input bit hld, input bit tick, input int step,
                                           input int cmax, input int cmin);
        mstate_t n;
        int cl;
        int d;
        int mag;
        n = m;
        n.settled = 1'b0;
        n.dac = fmt_ob(m.cur);
        cl = (code > cmax) ? cmax : ((code < cmin) ? cmin : code);
        if (valid) begin
            n.tgt = cl;
            n.clamped = (cl != code);
        end
        if (step == 0) begin
            if (!hld && (n.tgt != m.cur)) begin
                n.cur = n.tgt;
                n.settled = 1'b1;
            end
        end else if (!m.ramp) begin
            if (valid && (cl != m.cur)) n.ramp = 1'b1;
        end else if (tick && !hld) begin
            d   = m.tgt - m.cur;
            mag = (d < 0) ? -d : d;
            if (mag > step) mag = step;
            n.cur = m.cur + ((d < 0) ? -mag : mag);
            if (n.cur == n.tgt) begin
                n.ramp = 1'b0;
                n.settled = 1'b1;
            end
        end
        return n;
    endfunction

    initial begin
        mstate_t ma;
        mstate_t mb;
        int edge_k;
        ma = '0;
        ma.dac = fmt_ob(0);
        mb = ma;
        edge_k = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ma = '0;
                ma.dac = fmt_ob(0);
                mb = ma;
                edge_k = 0;
            end else begin
                ma = model_edge(ma, int'(code_in), code_valid, hold,
                                (edge_k % A_DIV) == A_DIV - 1, A_STEP, A_MAX, A_MIN);
                mb = model_edge(mb, int'(code_in), code_valid, 1'b0,
                                (edge_k % B_DIV) == B_DIV - 1, B_STEP, B_MAX, B_MIN);
                edge_k++;
                exp_q.push_back('{a: ma, b: mb});
                if (ma.settled) settle_q.push_back(ma.cur);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                settle_q.delete();
                check("rst_a_dac",     32'(a_dac),     'h2000);
                check("rst_a_cur",     32'(a_cur),     0);
                check("rst_a_busy",    32'(a_busy),    0);
                check("rst_a_settled", 32'(a_settled), 0);
                check("rst_a_clamped", 32'(a_clamped), 0);
                check("rst_b_dac",     32'(b_dac),     'h2000);
                check("rst_b_cur",     32'(b_cur),     0);
            end else if (exp_q.size() == 0) begin
                fail_now("scoreboard_underflow");
            end else begin
                e = exp_q.pop_front();
                check("a_cur",     32'(a_cur),     e.a.cur);
                check("a_dac",     32'(a_dac),     e.a.dac);
                check("a_busy",    32'(a_busy),    32'(e.a.ramp));
                check("a_settled", 32'(a_settled), 32'(e.a.settled));
                check("a_clamped", 32'(a_clamped), 32'(e.a.clamped));
                check("b_cur",     32'(b_cur),     e.b.cur);
                check("b_dac",     32'(b_dac),     e.b.dac);
                check("b_busy",    32'(b_busy),    0);
                check("b_settled", 32'(b_settled), 32'(e.b.settled));
                check("b_clamped", 32'(b_clamped), 32'(e.b.clamped));
                if (a_settled) begin
                    if (settle_q.size() == 0)
                        fail_now("a_settle_unexpected");
                    else
                        check("a_settle_code", 32'(a_cur), settle_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int code);
        code_in    = W'(code);
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic wait_settle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_settled && n < budget);
        if (!a_settled) fail_now("settle_timeout");
    endtask

    task automatic wait_cur_ge(input int level, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(a_cur) < level && n < budget);
        if (int'(a_cur) < level) fail_now("cur_level_timeout");
    endtask

    function automatic int pick_code(input int prev);
        int c;
        case ($urandom_range(0, 3))
            0:       c = int'($urandom_range(0, 16383)) - 8192;
            1:       c = A_MAX + int'($urandom_range(0, 4191));
            2:       c = prev + int'($urandom_range(0, 200)) - 100;
            default: c = int'($urandom_range(0, 3000)) - 1500;
        endcase
        if (c > 8191)  c = 8191;
        if (c < -8192) c = -8192;
        return c;
    endfunction

    initial begin
        int prev;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: midscale on the pins, nothing moving.
        repeat (50) @(negedge clk);
        check("idle_dac",  32'(a_dac),  'h2000);
        check("idle_cur",  32'(a_cur),  0);
        check("idle_busy", 32'(a_busy), 0);

        // Ramp 0 -> 1000.
        send(1000);
        wait_settle(300);
        check("ramp1000_cur",  32'(a_cur),  1000);
        check("ramp1000_busy", 32'(a_busy), 0);
        @(negedge clk);
        check("ramp1000_dac", 32'(a_dac), 'h23E8);

        // Reverse mid-ramp: rising past 500, retarget to -200.
        send(400);
        wait_settle(200);
        send(1000);
        wait_cur_ge(500, 200);
        send(-200);
        wait_settle(400);
        check("retarget_cur", 32'(a_cur), -200);

        // Clamp above CODE_MAX, then an in-range code clears the flag.
        send(8000);
        @(negedge clk);
        check("clamp_flag_set", 32'(a_clamped), 1);
        wait_settle(800);
        check("clamp_cur", 32'(a_cur), A_MAX);
        send(100);
        @(negedge clk);
        check("clamp_flag_clear", 32'(a_clamped), 0);
        wait_settle(800);

        // Hold during a ramp.
        send(-3000);
        repeat (20) @(negedge clk);
        hold = 1'b1;
        repeat (40) @(negedge clk);
        check("hold_busy", 32'(a_busy), 1);
        hold = 1'b0;
        wait_settle(1000);
        check("hold_end_cur", 32'(a_cur), -3000);

        // Unlimited instance: one-cycle jump, pins one cycle later.
        send(-8192);
        @(negedge clk);
        check("nolimit_cur",     32'(b_cur),     -8192);
        check("nolimit_settled", 32'(b_settled), 1);
        check("nolimit_busy",    32'(b_busy),    0);
        @(negedge clk);
        check("nolimit_dac", 32'(b_dac), 'h0000);

        // Asynchronous reset in the middle of a ramp.
        send(3000);
        repeat (30) @(negedge clk);
        check("pre_reset_busy", 32'(a_busy), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_a_dac",  32'(a_dac),  'h2000);
        check("async_a_cur",  32'(a_cur),  0);
        check("async_a_busy", 32'(a_busy), 0);
        check("async_b_dac",  32'(b_dac),  'h2000);
        check("async_b_cur",  32'(b_cur),  0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Random traffic with hold toggling.
        prev = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            code_valid = ($urandom_range(0, 39) == 0);
            if (code_valid) begin
                prev    = pick_code(prev);
                code_in = W'(prev);
            end
            if ($urandom_range(0, 49) == 0) hold = ~hold;
        end
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        hold       = 1'b0;
        @(negedge clk);
        #1;
        check("settle_queue_drained", settle_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
